// File: rtl/drc_pkg.sv
// drc_pkg: shared definitions for the DVP RX capture controller.
//   - rx_state_t    : capture FSM state encodings (also the cam_rx_state codes)
//   - RX_MODE_*     : cam_rx_mode codes; codes 2 and 3 behave as single capture
//   - is_cont_mode  : decodes continuous capture from the mode field
package drc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_DONE    = 3'd3,
        ST_ERROR   = 3'd4
    } rx_state_t;

    localparam logic [1:0] RX_MODE_SINGLE = 2'd0;
    localparam logic [1:0] RX_MODE_CONT   = 2'd1;

    // Reserved codes fall through to single capture.
    function automatic logic is_cont_mode(input logic [1:0] mode);
        return (mode == RX_MODE_CONT);
    endfunction

endpackage

// File: rtl/drc_rx_ctrl_if.sv
// drc_rx_ctrl_if: valid/ready pixel stream from the RX controller to the
// DMA/buffer stage.
//   m_pxl_data_o  : RGB565 pixel, first DVP byte of the pair in [15:8]
//   m_pxl_sof_o   : first pixel of the frame
//   m_pxl_eol_o   : pixel at column img_width-1
//   m_pxl_valid_o : pixel valid
//   m_pxl_ready_i : sink ready
// Modports: master (pixel producer), slave (pixel consumer).
interface drc_rx_ctrl_if
    import drc_pkg::*;
#(
    parameter int PXL_DATA_W = 16
);
    logic [PXL_DATA_W-1:0] m_pxl_data_o;
    logic                  m_pxl_sof_o;
    logic                  m_pxl_eol_o;
    logic                  m_pxl_valid_o;
    logic                  m_pxl_ready_i;

    modport master (
        output m_pxl_data_o,
        output m_pxl_sof_o,
        output m_pxl_eol_o,
        output m_pxl_valid_o,
        input  m_pxl_ready_i
    );

    modport slave (
        input  m_pxl_data_o,
        input  m_pxl_sof_o,
        input  m_pxl_eol_o,
        input  m_pxl_valid_o,
        output m_pxl_ready_i
    );
endinterface

// File: rtl/drc_rx_pxl_pack.sv
// drc_rx_pxl_pack: byte-pair packer with a one-entry output register.
// Ports:
//   aclk, areset : clock, synchronous active-high reset
//   byte_en      : strobed DVP byte inside a line while capturing
//   byte_data    : the DVP byte
//   line_end     : strobed href falling edge while capturing
//   phase_clr    : restart byte pairing (start of capture)
//   flush        : drop any held pixel (controller disabled)
//   sof_tag      : sideband for the pixel completing this cycle
//   eol_tag      : sideband for the pixel completing this cycle
//   pxl_cmp      : a low byte completes a pixel this cycle
//   pxl_load     : the completed pixel enters the output register
//   pxl_ovf      : the completed pixel is dropped (output still blocked)
//   odd_err      : line ended on a dangling high byte
//   pxl          : pixel stream master
module drc_rx_pxl_pack
    import drc_pkg::*;
#(
    parameter int DVP_DATA_W = 8,
    parameter int PXL_DATA_W = 16
)(
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  byte_en,
    input  logic [DVP_DATA_W-1:0] byte_data,
    input  logic                  line_end,
    input  logic                  phase_clr,
    input  logic                  flush,
    input  logic                  sof_tag,
    input  logic                  eol_tag,
    output logic                  pxl_cmp,
    output logic                  pxl_load,
    output logic                  pxl_ovf,
    output logic                  odd_err,
    drc_rx_ctrl_if.master         pxl
);

    logic                  phase_p0;
    logic [DVP_DATA_W-1:0] hi_byte_p0;

    // A completing pixel may load when the register is empty or is being
    // emptied this very cycle, which gives back-to-back reload without a gap.
    assign pxl_cmp  = byte_en & phase_p0;
    assign pxl_load = pxl_cmp & (~pxl.m_pxl_valid_o | pxl.m_pxl_ready_i);
    assign pxl_ovf  = pxl_cmp & pxl.m_pxl_valid_o & ~pxl.m_pxl_ready_i;
    assign odd_err  = line_end & phase_p0;

    // Stage p0: byte phase and high-byte capture
    always_ff @(posedge aclk) begin
        if (areset || phase_clr || line_end) begin
            phase_p0 <= 1'b0;
        end else if (byte_en) begin
            phase_p0 <= ~phase_p0;
        end
    end

    always_ff @(posedge aclk) begin
        if (byte_en && !phase_p0) begin
            hi_byte_p0 <= byte_data;
        end
    end

    // Stage p1: output register
    always_ff @(posedge aclk) begin
        if (areset) begin
            pxl.m_pxl_valid_o <= 1'b0;
            pxl.m_pxl_data_o  <= '0;
            pxl.m_pxl_sof_o   <= 1'b0;
            pxl.m_pxl_eol_o   <= 1'b0;
        end else begin
            if (flush) begin
                pxl.m_pxl_valid_o <= 1'b0;
            end else if (pxl_load) begin
                pxl.m_pxl_valid_o <= 1'b1;
            end else if (pxl.m_pxl_ready_i) begin
                pxl.m_pxl_valid_o <= 1'b0;
            end
            if (pxl_load) begin
                pxl.m_pxl_data_o <= PXL_DATA_W'({hi_byte_p0, byte_data});
                pxl.m_pxl_sof_o  <= sof_tag;
                pxl.m_pxl_eol_o  <= eol_tag;
            end
        end
    end

endmodule

// File: rtl/drc_rx_ctrl.sv
// drc_rx_ctrl: DVP camera RX capture controller.
// Samples synchronised DVP traffic, packs byte pairs into RGB565 pixels and
// streams them out; runs the capture FSM, counters and interrupts.
// Build option: define DRC_RX_FRAME_CHECK_EN to compile in frame-dimension
// checking (line pixel count vs img_width, frame line count vs img_height).
// Ports:
//   aclk, areset       : clock, synchronous active-high reset
//   cam_rx_en          : enable; low aborts to IDLE
//   cam_rx_mode        : 0 single, 1 continuous, 2/3 single
//   cam_rx_start       : pending start request
//   cam_rx_start_qed   : one-cycle pop of the start request
//   cam_rx_state       : FSM state code
//   cam_rx_len         : pixels delivered in the current/last frame
//   img_width/height   : expected frame dimensions
//   irq_msk_frm_*      : 1 suppresses the matching interrupt
//   irq_frm_comp_o     : frame complete pulse
//   irq_frm_err_o      : frame error pulse
//   dvp_smpl_en_i      : DVP byte strobe
//   dvp_vsync_i/href_i : frame sync / line valid
//   dvp_d_i            : DVP byte
//   pxl                : pixel stream master
module drc_rx_ctrl
    import drc_pkg::*;
#(
    parameter int IMG_DIM_MAX = 640,
    parameter int IMG_DIM_W   = $clog2(IMG_DIM_MAX),
    parameter int DVP_DATA_W  = 8,
    parameter int PXL_DATA_W  = 2 * DVP_DATA_W
)(
    input  logic                   aclk,
    input  logic                   areset,
    input  logic                   cam_rx_en,
    input  logic [1:0]             cam_rx_mode,
    input  logic                   cam_rx_start,
    output logic                   cam_rx_start_qed,
    output logic [2:0]             cam_rx_state,
    output logic [2*IMG_DIM_W-1:0] cam_rx_len,
    input  logic [IMG_DIM_W-1:0]   img_width,
    input  logic [IMG_DIM_W-1:0]   img_height,
    input  logic                   irq_msk_frm_comp,
    input  logic                   irq_msk_frm_err,
    output logic                   irq_frm_comp_o,
    output logic                   irq_frm_err_o,
    input  logic                   dvp_smpl_en_i,
    input  logic                   dvp_vsync_i,
    input  logic                   dvp_href_i,
    input  logic [DVP_DATA_W-1:0]  dvp_d_i,
    drc_rx_ctrl_if.master          pxl
);

    localparam int LEN_W = 2 * IMG_DIM_W;

    function automatic logic [LEN_W-1:0] len_sat_inc(input logic [LEN_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    rx_state_t            state;
    logic                 vsync_prev_p0;
    logic                 href_prev_p0;
    logic                 vsync_fall;
    logic                 vsync_rise;
    logic                 href_fall;
    logic                 in_cap;
    logic                 cap_start;
    logic                 byte_en;
    logic                 line_end;
    logic                 flush;
    logic [IMG_DIM_W-1:0] col_cnt;
    logic [IMG_DIM_W-1:0] line_cnt;
    logic [IMG_DIM_W-1:0] last_col;
    logic                 sof_pend;
    logic                 err_flag;
    logic                 err_now;
    logic                 dim_err;
    logic                 pxl_cmp;
    logic                 pxl_load;
    logic                 pxl_ovf;
    logic                 odd_err;
    logic [LEN_W-1:0]     len_cnt;

    // Edges are judged only between strobed samples; unstrobed cycles leave
    // the history untouched so their values never look like transitions.
    assign vsync_fall = dvp_smpl_en_i &  vsync_prev_p0 & ~dvp_vsync_i;
    assign vsync_rise = dvp_smpl_en_i & ~vsync_prev_p0 &  dvp_vsync_i;
    assign href_fall  = dvp_smpl_en_i &  href_prev_p0  & ~dvp_href_i;

    assign in_cap    = cam_rx_en && (state == ST_CAPTURE);
    assign cap_start = cam_rx_en && (state == ST_ARMED) && vsync_fall;
    assign byte_en   = in_cap & dvp_smpl_en_i & dvp_href_i;
    assign line_end  = in_cap & href_fall;
    assign flush     = ~cam_rx_en;
    assign last_col  = img_width - 1'b1;

`ifdef DRC_RX_FRAME_CHECK_EN
    logic [IMG_DIM_W-1:0] lines_now;
    // A line end in the same strobe as frame end still counts as a line.
    assign lines_now = line_cnt + {{(IMG_DIM_W-1){1'b0}}, line_end};
    assign dim_err   = (line_end && (col_cnt != img_width)) ||
                       (vsync_rise && (lines_now != img_height));
`else
    logic unused_img_height;
    assign unused_img_height = ^img_height;
    assign dim_err           = 1'b0;
`endif

    // Errors raised in the frame-end strobe itself still steer to ERROR.
    assign err_now = err_flag | odd_err | pxl_ovf | dim_err;

    // Stage p0: strobed sync history
    always_ff @(posedge aclk) begin
        if (areset) begin
            vsync_prev_p0 <= 1'b0;
            href_prev_p0  <= 1'b0;
        end else if (dvp_smpl_en_i) begin
            vsync_prev_p0 <= dvp_vsync_i;
            href_prev_p0  <= dvp_href_i;
        end
    end

    drc_rx_pxl_pack #(
        .DVP_DATA_W (DVP_DATA_W),
        .PXL_DATA_W (PXL_DATA_W)
    ) u_pack (
        .aclk      (aclk),
        .areset    (areset),
        .byte_en   (byte_en),
        .byte_data (dvp_d_i),
        .line_end  (line_end),
        .phase_clr (cap_start),
        .flush     (flush),
        .sof_tag   (sof_pend),
        .eol_tag   (col_cnt == last_col),
        .pxl_cmp   (pxl_cmp),
        .pxl_load  (pxl_load),
        .pxl_ovf   (pxl_ovf),
        .odd_err   (odd_err),
        .pxl       (pxl)
    );

    // Stage p1: capture FSM with registered pulses
    always_ff @(posedge aclk) begin
        if (areset) begin
            state            <= ST_IDLE;
            cam_rx_start_qed <= 1'b0;
            irq_frm_comp_o   <= 1'b0;
            irq_frm_err_o    <= 1'b0;
        end else begin
            cam_rx_start_qed <= 1'b0;
            irq_frm_comp_o   <= 1'b0;
            irq_frm_err_o    <= 1'b0;
            if (!cam_rx_en) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (cam_rx_start) begin
                            state            <= ST_ARMED;
                            cam_rx_start_qed <= 1'b1;
                        end
                    end
                    ST_ARMED: begin
                        if (vsync_fall) state <= ST_CAPTURE;
                    end
                    ST_CAPTURE: begin
                        if (vsync_rise) begin
                            if (err_now) begin
                                state         <= ST_ERROR;
                                irq_frm_err_o <= ~irq_msk_frm_err;
                            end else begin
                                state          <= ST_DONE;
                                irq_frm_comp_o <= ~irq_msk_frm_comp;
                            end
                        end
                    end
                    ST_DONE, ST_ERROR: begin
                        state <= is_cont_mode(cam_rx_mode) ? ST_ARMED : ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // Stage p1: frame counters; everything holds outside an enabled capture
    always_ff @(posedge aclk) begin
        if (areset) begin
            col_cnt  <= '0;
            line_cnt <= '0;
            len_cnt  <= '0;
            sof_pend <= 1'b0;
            err_flag <= 1'b0;
        end else if (cap_start) begin
            col_cnt  <= '0;
            line_cnt <= '0;
            len_cnt  <= '0;
            sof_pend <= 1'b1;
            err_flag <= 1'b0;
        end else if (in_cap) begin
            // Dropped pixels still occupy a column so eol stays aligned.
            if (pxl_cmp) begin
                col_cnt  <= col_cnt + 1'b1;
                sof_pend <= 1'b0;
            end
            if (line_end) begin
                col_cnt  <= '0;
                line_cnt <= line_cnt + 1'b1;
            end
            if (pxl_load) len_cnt <= len_sat_inc(len_cnt);
            if (err_now)  err_flag <= 1'b1;
        end
    end

    assign cam_rx_state = state;
    assign cam_rx_len   = len_cnt;

endmodule

// File: tb/tb_drc_rx_ctrl.sv
module tb_drc_rx_ctrl;
    import drc_pkg::*;

    logic        aclk = 1'b0;
    logic        areset;
    logic        cam_rx_en;
    logic [1:0]  cam_rx_mode;
    logic        cam_rx_start;
    logic        cam_rx_start_qed;
    logic [2:0]  cam_rx_state;
    logic [19:0] cam_rx_len;
    logic [9:0]  img_width;
    logic [9:0]  img_height;
    logic        irq_msk_frm_comp;
    logic        irq_msk_frm_err;
    logic        irq_frm_comp_o;
    logic        irq_frm_err_o;
    logic        dvp_smpl_en_i;
    logic        dvp_vsync_i;
    logic        dvp_href_i;
    logic [7:0]  dvp_d_i;

    always #5 aclk = ~aclk;

    drc_rx_ctrl_if #(.PXL_DATA_W(16)) pif ();

    drc_rx_ctrl dut (
        .aclk             (aclk),
        .areset           (areset),
        .cam_rx_en        (cam_rx_en),
        .cam_rx_mode      (cam_rx_mode),
        .cam_rx_start     (cam_rx_start),
        .cam_rx_start_qed (cam_rx_start_qed),
        .cam_rx_state     (cam_rx_state),
        .cam_rx_len       (cam_rx_len),
        .img_width        (img_width),
        .img_height       (img_height),
        .irq_msk_frm_comp (irq_msk_frm_comp),
        .irq_msk_frm_err  (irq_msk_frm_err),
        .irq_frm_comp_o   (irq_frm_comp_o),
        .irq_frm_err_o    (irq_frm_err_o),
        .dvp_smpl_en_i    (dvp_smpl_en_i),
        .dvp_vsync_i      (dvp_vsync_i),
        .dvp_href_i       (dvp_href_i),
        .dvp_d_i          (dvp_d_i),
        .pxl              (pif)
    );

    int total = 0;
    int bad   = 0;
    int comp_cnt = 0;
    int err_cnt  = 0;
    int qed_cnt  = 0;
    logic [17:0] sb_q[$];
    logic        hold_prev = 1'b0;
    logic [17:0] hold_val;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: pulse counters, hold-stability check, scoreboard pop.
    always @(negedge aclk) begin
        logic [17:0] cur;
        logic [17:0] exp;
        cur = {pif.m_pxl_data_o, pif.m_pxl_sof_o, pif.m_pxl_eol_o};
        if (!areset) begin
            if (irq_frm_comp_o)   comp_cnt++;
            if (irq_frm_err_o)    err_cnt++;
            if (cam_rx_start_qed) qed_cnt++;
            if (hold_prev && cam_rx_en) chk("hold", {13'd0, pif.m_pxl_valid_o, cur}, {13'd0, 1'b1, hold_val});
            if (pif.m_pxl_valid_o && pif.m_pxl_ready_i) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_pixel", int'(cur), -1);
                end else begin
                    exp = sb_q.pop_front();
                    chk("pixel", int'(cur), int'(exp));
                end
            end
            hold_prev = pif.m_pxl_valid_o && !pif.m_pxl_ready_i;
            hold_val  = cur;
        end else begin
            hold_prev = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not end, bad=%0d", bad);
        $fatal(1, "watchdog expired");
    end

    task automatic step(input bit s, input bit vs, input bit hr, input logic [7:0] d);
        dvp_smpl_en_i = s;
        dvp_vsync_i   = vs;
        dvp_href_i    = hr;
        dvp_d_i       = d;
        @(posedge aclk);
        #1;
    endtask

    // Sends vsync preamble and all lines (stopping before frame end), pushing
    // the pixels that should reach the stream. With stall, ready is held low
    // from pixel 0's low byte through pixel 1's low byte, so pixel 1 drops.
    task automatic send_frame(input int w, input int nl, input int odd_line, input bit stall);
        int p;
        int col;
        int nbytes;
        logic [7:0] d;
        logic [7:0] hi;
        step(1, 1, 0, 8'h00);
        step(0, 0, 1, 8'h5a);
        chk("armed_ignores_unstrobed", cam_rx_state, 1);
        step(1, 0, 0, 8'h00);
        chk("capture_entry", cam_rx_state, 2);
        p = 0;
        hi = 8'h00;
        for (int ln = 0; ln < nl; ln++) begin
            nbytes = (ln == odd_line) ? 2 * w - 1 : 2 * w;
            col = 0;
            for (int b = 0; b < nbytes; b++) begin
                d = 8'($urandom_range(0, 255));
                if (b % 2 == 0) hi = d;
                if (b % 2 == 1 && stall && p == 0) pif.m_pxl_ready_i = 1'b0;
                step(1, 0, 1, d);
                if (b % 2 == 1) begin
                    if (!(stall && p == 1)) sb_q.push_back({hi, d, (p == 0), (col == w - 1)});
                    if (stall && p == 1) pif.m_pxl_ready_i = 1'b1;
                    p++;
                    col++;
                end
                step(0, 1, 0, ~d);
            end
            step(1, 0, 0, 8'h00);
            step(1, 0, 0, 8'h00);
        end
    endtask

    typedef struct {
        int w; int himg; int nl; int odd_line; bit stall; bit mc; bit me;
        int exp_len; int exp_state; int exp_comp; int exp_err;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int c0, e0, q0;
        vecs[0] = '{4, 2, 2, -1, 1'b0, 1'b0, 1'b0, 8, 3, 1, 0};
        vecs[1] = '{4, 2, 2,  0, 1'b0, 1'b0, 1'b0, 7, 4, 0, 1};
        vecs[2] = '{4, 2, 2, -1, 1'b1, 1'b0, 1'b0, 7, 4, 0, 1};
        vecs[3] = '{4, 2, 2, -1, 1'b1, 1'b0, 1'b1, 7, 4, 0, 0};
`ifdef DRC_RX_FRAME_CHECK_EN
        vecs[4] = '{4, 3, 2, -1, 1'b0, 1'b0, 1'b0, 8, 4, 0, 1};
`else
        vecs[4] = '{4, 3, 2, -1, 1'b0, 1'b0, 1'b0, 8, 3, 1, 0};
`endif
        vecs[5] = '{3, 3, 3, -1, 1'b0, 1'b0, 1'b0, 9, 3, 1, 0};
        vecs[6] = '{2, 1, 1, -1, 1'b0, 1'b1, 1'b0, 2, 3, 0, 0};

        areset = 1'b1; cam_rx_en = 1'b0; cam_rx_mode = 2'd0; cam_rx_start = 1'b0;
        img_width = 10'd4; img_height = 10'd2; irq_msk_frm_comp = 1'b0; irq_msk_frm_err = 1'b0;
        dvp_smpl_en_i = 1'b0; dvp_vsync_i = 1'b0; dvp_href_i = 1'b0; dvp_d_i = 8'h00;
        pif.m_pxl_ready_i = 1'b1;
        repeat (3) step(0, 0, 0, 8'h00);
        areset = 1'b0;
        step(0, 0, 0, 8'h00);
        chk("rst_state", cam_rx_state, 0);
        chk("rst_len", int'(cam_rx_len), 0);
        chk("rst_valid", pif.m_pxl_valid_o, 0);
        chk("rst_data", pif.m_pxl_data_o, 0);
        chk("rst_pulses", {cam_rx_start_qed, irq_frm_comp_o, irq_frm_err_o}, 0);

        // Table-driven single-capture frames.
        cam_rx_en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            img_width = 10'(vecs[i].w);
            img_height = 10'(vecs[i].himg);
            irq_msk_frm_comp = vecs[i].mc;
            irq_msk_frm_err = vecs[i].me;
            c0 = comp_cnt; e0 = err_cnt; q0 = qed_cnt;
            cam_rx_start = 1'b1;
            step(0, 0, 0, 8'h00);
            chk("arm_state", cam_rx_state, 1);
            chk("start_qed", cam_rx_start_qed, 1);
            cam_rx_start = 1'b0;
            step(0, 0, 0, 8'h00);
            chk("start_qed_width", cam_rx_start_qed, 0);
            send_frame(vecs[i].w, vecs[i].nl, vecs[i].odd_line, vecs[i].stall);
            step(1, 1, 0, 8'h00);
            chk("end_state", cam_rx_state, vecs[i].exp_state);
            step(0, 0, 0, 8'h00);
            chk("after_end_state", cam_rx_state, 0);
            step(0, 0, 0, 8'h00);
            step(0, 0, 0, 8'h00);
            chk("len", int'(cam_rx_len), vecs[i].exp_len);
            chk("comp_irqs", comp_cnt - c0, vecs[i].exp_comp);
            chk("err_irqs", err_cnt - e0, vecs[i].exp_err);
            chk("qed_count", qed_cnt - q0, 1);
            chk("sb_drained", sb_q.size(), 0);
        end

        // Continuous mode: one accepted request, three frames. A second
        // request raised mid-capture must stay queued until IDLE.
        irq_msk_frm_comp = 1'b0; irq_msk_frm_err = 1'b0;
        img_width = 10'd4; img_height = 10'd2; cam_rx_mode = 2'd1;
        c0 = comp_cnt; e0 = err_cnt; q0 = qed_cnt;
        cam_rx_start = 1'b1;
        step(0, 0, 0, 8'h00);
        cam_rx_start = 1'b0;
        for (int f = 0; f < 3; f++) begin
            send_frame(4, 2, -1, 1'b0);
            cam_rx_start = 1'b1;
            step(1, 1, 0, 8'h00);
            chk("cont_done", cam_rx_state, 3);
            step(0, 0, 0, 8'h00);
            chk("cont_rearm", cam_rx_state, 1);
        end
        chk("cont_len", int'(cam_rx_len), 8);
        chk("cont_comp_irqs", comp_cnt - c0, 3);
        chk("cont_err_irqs", err_cnt - e0, 0);
        chk("cont_qed_once", qed_cnt - q0, 1);
        cam_rx_en = 1'b0;
        step(0, 0, 0, 8'h00);
        chk("cont_abort_idle", cam_rx_state, 0);
        step(0, 0, 0, 8'h00);
        chk("queued_held_while_disabled", qed_cnt - q0, 1);
        cam_rx_en = 1'b1;
        step(0, 0, 0, 8'h00);
        chk("queued_popped", cam_rx_start_qed, 1);
        cam_rx_start = 1'b0;
        cam_rx_en = 1'b0;
        step(0, 0, 0, 8'h00);
        cam_rx_mode = 2'd0;
        cam_rx_en = 1'b1;
        step(0, 0, 0, 8'h00);
        chk("cont_cleanup_idle", cam_rx_state, 0);

        // Enable dropped mid-line with a pixel held in the output register.
        c0 = comp_cnt; e0 = err_cnt;
        cam_rx_start = 1'b1;
        step(0, 0, 0, 8'h00);
        cam_rx_start = 1'b0;
        step(1, 1, 0, 8'h00);
        step(1, 0, 0, 8'h00);
        chk("abort_capture", cam_rx_state, 2);
        pif.m_pxl_ready_i = 1'b0;
        step(1, 0, 1, 8'h12);
        step(1, 0, 1, 8'h34);
        step(1, 0, 1, 8'h56);
        chk("abort_held_valid", pif.m_pxl_valid_o, 1);
        chk("abort_held_data", pif.m_pxl_data_o, 16'h1234);
        cam_rx_en = 1'b0;
        step(1, 0, 1, 8'h78);
        chk("abort_idle", cam_rx_state, 0);
        chk("abort_valid_clear", pif.m_pxl_valid_o, 0);
        step(1, 1, 0, 8'h00);
        step(0, 0, 0, 8'h00);
        chk("abort_len_hold", int'(cam_rx_len), 1);
        chk("abort_no_irq", (comp_cnt - c0) + (err_cnt - e0), 0);
        chk("abort_still_idle", cam_rx_state, 0);
        pif.m_pxl_ready_i = 1'b1;
        cam_rx_en = 1'b1;
        step(0, 0, 0, 8'h00);
        step(0, 0, 0, 8'h00);
        chk("abort_sb_empty", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
